multicycle_controller: RTL

//   Multi-cycle control FSM for the 8-bit datapath: sequences program_counter, instructMem,

---
 rtl/multicycle_controller_pkg.sv | 33 +++
 rtl/mem_timeout_counter.sv | 31 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, FSM states and error codes for the multi-cycle controller.
// Used by the controller, its sub-modules and the datapath benches.
package multicycle_controller_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQZ = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_e;

  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on a data-memory ack.
// expired_o is high in the last permitted wait cycle.
module mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && !expired_o)
      cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// start/halt handshake, memory req/ack with timeout, retire counter.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_load,
  output logic             registerwrite,
  output logic             aluop,
  output logic             alusrc,
  output logic             reg2mem,
  output logic             mem_req,
  output logic             memw,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             to_expired;

  mem_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_to (
    .clk       (sysclk),
    .rst_n     (rst_n),
    .clear_i   (state_q != S_MEM),
    .enable_i  (state_q == S_MEM),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    err_d         = err_q;
    retire        = 1'b0;
    ir_load       = 1'b0;
    pc_en         = 1'b0;
    pc_load       = 1'b0;
    registerwrite = 1'b0;
    aluop         = 1'b0;
    alusrc        = 1'b0;
    reg2mem       = 1'b0;
    mem_req       = 1'b0;
    memw          = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        pc_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = opcode;
        unique case (1'b1)
          (opcode == OP_HALT): begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          (opcode == OP_RSV): begin
            state_d = S_ERR;
            err_d   = ERR_ILLEGAL;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        aluop  = (op_q == OP_SUB) || (op_q == OP_BEQZ);
        alusrc = uses_imm(op_q);
        unique case (1'b1)
          (op_q == OP_LW),
          (op_q == OP_SW): state_d = S_MEM;
          (op_q == OP_BEQZ): begin
            pc_load = zero;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        memw    = (op_q == OP_SW);
        alusrc  = 1'b1;
        if (mem_ack) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (to_expired) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        registerwrite = 1'b1;
        reg2mem       = (op_q == OP_LW);
        aluop         = (op_q == OP_SUB);
        alusrc        = uses_imm(op_q);
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_HALT: halted = 1'b1;
      S_ERR: ;
    endcase
  end

  // Retire counter saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_HALT) &&
                (state_q != S_ERR);
  assign err_code    = err_q;
  assign instr_count = cnt_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
